i2s_serial_sample_fifo: RTL and testbench
=========================================

Name: i2s_serial_sample_fifo

Overview:
- Successor to the single-channel Pi shift-in buffer.
- Deserialises a bit stream clocked by the Raspberry Pi into WIDTH-bit samples and stores them in a DEPTH-word circular FIFO. The FIFO is interleaved across CHANNELS.
- Delivers one sample per `ready` strobe to the I2S output stage.
- Requests refills from the Pi with a hysteresis watermark interrupt and reports overflow/underrun.
- Everything runs in the `clk` domain. `rpi_clk` and `serial` are synchronised inside the block.

Parameters:
- WIDTH, 16: sample width in bits (2..32).
- DEPTH, 64: FIFO depth in words. Must be a power of two, 4..1024.
- CHANNELS, 2: channels interleaved per frame (1..8).
- MSB_FIRST, 0: 0 = first received bit is bit 0; 1 = first received bit is bit WIDTH-1.
- LOW_WATER, 16: assert `rpi_interrupt` when level <= LOW_WATER.
- HIGH_WATER, 48: deassert `rpi_interrupt` when level >= HIGH_WATER. Requires LOW_WATER < HIGH_WATER <= DEPTH.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous, active-high reset.
- rpi_clk  in  1  shift clock from the Pi; asynchronous to `clk`.
- serial  in  1  serial data from the Pi; asynchronous to `clk`.
- ready  in  1  single-cycle strobe in the `clk` domain: present the next sample.
- rpi_interrupt  out  1  request more data from the Pi.
- data  out  WIDTH  current output sample (signed).
- channel  out  clog2(CHANNELS) (min 1)  channel index of `data`.
- data_valid  out  1  one-cycle pulse when `data` is updated.
- level  out  clog2(DEPTH)+1  number of words stored.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- underrun  out  1  sticky: `ready` arrived while the FIFO was empty.

Behaviour:
- Reset, synchronous on `clk` while `rst`=1:
  - All pointers, bit counter, `level` and `channel` = 0.
  - `data` = 0; `data_valid`, `overflow`, `underrun` = 0.
  - `rpi_interrupt` = 1, since the FIFO is empty.
  - FIFO contents are don't-care.
  - A reset mid-word discards the partial word.
- Input sync:
  - `rpi_clk` and `serial` each pass through a 2-flop synchroniser.
  - A bit is captured on the cycle the synchronised `rpi_clk` shows a 0->1 transition.
  - The Pi guarantees at least 3 `clk` cycles each for `rpi_clk` high and low.
- Shift:
  - The bit counter runs 0..WIDTH-1. The bit is placed at index = counter (MSB_FIRST=0) or index = WIDTH-1-counter (MSB_FIRST=1).
  - On the WIDTH-th bit the completed word is pushed in the same cycle and the counter wraps to 0.
- Push:
  - If level < DEPTH, write at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
  - If level == DEPTH with no pop in the same cycle, drop the word, set `overflow`, and leave `wr_ptr` unchanged.
  - A full FIFO with a simultaneous pop accepts the push.
- Pop on `ready`=1:
  - If level > 0: next cycle `data` = mem[`rd_ptr`] and `data_valid`=1 for one cycle. `channel` advances modulo CHANNELS and `rd_ptr` increments modulo DEPTH.
  - Read latency is 1 cycle from `ready`.
  - If level == 0: `data` = 0 (silence), `data_valid`=1, `underrun` set.
  - On underrun, `channel` still advances so the stereo frame stays aligned. `rd_ptr` is unchanged.
  - There is no write-to-read bypass: a push and a pop in the same cycle while empty is an underrun; the pushed word is stored.
- Level:
  - +1 on push only, -1 on pop only, unchanged when both or neither occur.
  - Never exceeds DEPTH and never goes below 0.
- Interrupt (registered):
  - Set when level <= LOW_WATER.
  - Cleared when level >= HIGH_WATER.
  - Holds its value between the two thresholds.
- Sticky flags clear only on `rst`.
- Channel alignment: sample n in the Pi stream is channel n mod CHANNELS. This holds as long as no overflow occurs; after an overflow, alignment is not guaranteed until reset.

Test Plan:
- Reset check: hold `rst` 2 cycles -> `level`=0, `data`=0, `rpi_interrupt`=1, `overflow`=0, `underrun`=0, `channel`=0.
- Bit order: WIDTH=16, MSB_FIRST=0, shift 16'h1234 LSB-first, then pulse `ready` -> one cycle later `data`=16'h1234, `data_valid`=1, `channel`=0. Repeat with MSB_FIRST=1, sending MSB-first -> `data`=16'h1234.
- Watermark hysteresis: push 48 words -> `rpi_interrupt` falls on the cycle `level` reaches 48. Pop 31 (level 17) -> still 0. Pop 1 more (level 16) -> 1.
- Overflow: push 65 words 0..64 with no reads -> `level`=64, `overflow`=1. Then 64 pops return 0..63 in order; word 64 is lost.
- Underrun: with the FIFO empty, pulse `ready` twice -> `data`=0 both times, `underrun`=1, `channel` goes 1 then 0 (CHANNELS=2), `level` stays 0.
- Simultaneous push/pop plus wrap: keep `level`=1 while streaming 200 words with the word completion coinciding with `ready` -> `level` stays 1, output order is preserved across pointer wrap at 64, no flags set.

Source files
------------

// File: rtl/i2s_serial_sample_fifo.sv
// ----------------------------------------------------------------------------
// i2s_serial_sample_fifo
//
// Purpose:
//   Deserialises a bit stream that the Raspberry Pi shifts in on its own clock
//   into WIDTH-bit samples. Completed samples go into a DEPTH-word circular
//   FIFO. The I2S output stage drains the FIFO one sample per `ready` strobe.
//   Samples are interleaved across CHANNELS, so sample n of the stream belongs
//   to channel n mod CHANNELS. A hysteresis watermark interrupt asks the Pi for
//   more data. Sticky flags report dropped words (overflow) and reads from an
//   empty FIFO (underrun).
//
// Ports:
//   clk           in   main clock; every register in this block runs on it
//   rst           in   synchronous, active-high reset
//   rpi_clk       in   shift clock from the Pi (asynchronous to clk)
//   serial        in   serial data from the Pi (asynchronous to clk)
//   ready         in   one-cycle strobe: present the next sample
//   rpi_interrupt out  request more data (set at <= LOW_WATER,
//                      cleared at >= HIGH_WATER)
//   data          out  current output sample (signed); zero after an underrun
//   channel       out  channel index of `data`
//   data_valid    out  one-cycle pulse when `data`/`channel` update
//   level         out  number of words stored (0..DEPTH)
//   overflow      out  sticky: a completed word was dropped because the FIFO
//                      was full
//   underrun      out  sticky: `ready` arrived while the FIFO was empty
// ----------------------------------------------------------------------------
module i2s_serial_sample_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int CHANNELS   = 2,
    parameter int MSB_FIRST  = 0,
    parameter int LOW_WATER  = 16,
    parameter int HIGH_WATER = 48,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rpi_clk,
    input  logic                    serial,
    input  logic                    ready,
    output logic                    rpi_interrupt,
    output logic signed [WIDTH-1:0] data,
    output logic [CH_W-1:0]         channel,
    output logic                    data_valid,
    output logic [LVL_W-1:0]        level,
    output logic                    overflow,
    output logic                    underrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(WIDTH);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LOW_LVL  = LVL_W'(LOW_WATER);
    localparam logic [LVL_W-1:0] HIGH_LVL = LVL_W'(HIGH_WATER);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

    // ------------------------------------------------------------------
    // Input synchronisers and rising-edge detection.
    // ------------------------------------------------------------------
    logic rpi_clk_s1;
    logic rpi_clk_s2;
    logic rpi_clk_prev;
    logic serial_s1;
    logic serial_s2;
    logic capture;

    // `serial` goes through the same two stages as `rpi_clk`. The data bit
    // therefore lines up with the synchronised edge that captures it.
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples its pre-edge value, and the synchroniser chain stays two
    // stages deep regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpi_clk_s1   <= 1'b0;
            rpi_clk_s2   <= 1'b0;
            rpi_clk_prev <= 1'b0;
            serial_s1    <= 1'b0;
            serial_s2    <= 1'b0;
        end else begin
            rpi_clk_s1   <= rpi_clk;
            rpi_clk_s2   <= rpi_clk_s1;
            rpi_clk_prev <= rpi_clk_s2;
            serial_s1    <= serial;
            serial_s2    <= serial_s1;
        end
    end

    assign capture = rpi_clk_s2 && !rpi_clk_prev;

    // ------------------------------------------------------------------
    // Shift register and bit counter.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] shift_reg;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [WIDTH-1:0] word_next;
    logic             word_done;

    // The word is assembled in place rather than by shifting. Each bit goes
    // straight to its final index, so both bit orders share one datapath.
    // NOTE: every signal driven here gets a default first. No path can
    // leave a value unassigned, so no latch is inferred.
    always_comb begin
        bit_idx   = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt) : bit_cnt;
        word_next = shift_reg;
        word_next[bit_idx] = serial_s2;
    end

    // The last bit completes the word in the same cycle it is captured. The
    // push uses word_next and does not wait for shift_reg.
    assign word_done = capture && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Clearing here also throws away any partially received word.
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (capture) begin
            if (bit_cnt == LAST_BIT) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else begin
                bit_cnt   <= bit_cnt + 1'b1;
                shift_reg <= word_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and control.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CH_W-1:0]  rd_channel;   // channel of the next sample to present
    logic             pop;
    logic             push_ok;
    logic [LVL_W-1:0] level_next;
    logic             intr_next;

    assign pop = ready && (level != '0);

    // A full FIFO still accepts a word when a pop frees a slot in the same
    // cycle. When the FIFO is empty, `pop` is low, so a simultaneous push and
    // ready counts as an underrun and the pushed word is kept.
    assign push_ok = word_done && ((level != FULL_LVL) || pop);

    always_comb begin
        level_next = level;
        unique case ({push_ok, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase

        // The interrupt is registered from the next level. It therefore
        // changes on the same edge on which `level` crosses a threshold.
        intr_next = rpi_interrupt;
        if (level_next <= LOW_LVL) begin
            intr_next = 1'b1;
        end else if (level_next >= HIGH_LVL) begin
            intr_next = 1'b0;
        end
    end

    // NOTE: the storage array has no reset. Its contents are never visible
    // until a push has written them, and leaving out the reset lets the
    // array map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_channel    <= '0;
            level         <= '0;
            channel       <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
            rpi_interrupt <= 1'b1;
        end else begin
            data_valid    <= ready;
            level         <= level_next;
            rpi_interrupt <= intr_next;

            if (ready) begin
                // The channel advances on every strobe, including an
                // underrun, so the frame stays aligned.
                channel    <= rd_channel;
                rd_channel <= (rd_channel == LAST_CH) ? '0 : rd_channel + 1'b1;
                if (pop) begin
                    data   <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    data     <= '0;
                    underrun <= 1'b1;
                end
            end

            // DEPTH is a power of two, so the natural pointer wrap is the
            // modulo-DEPTH increment.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (word_done) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_serial_sample_fifo.sv
// ----------------------------------------------------------------------------
// Testbench for i2s_serial_sample_fifo.
// The reference model is a queue of stored words, a frame-position counter
// and flags. Each `ready` strobe pushes the expected sample and channel into a
// scoreboard. A separate monitor pops an entry and compares it whenever the
// DUT pulses data_valid.
// ----------------------------------------------------------------------------
module tb_i2s_serial_sample_fifo;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 64;
    localparam int CHANNELS = 2;
    localparam int LOW      = 16;
    localparam int HIGH     = 48;

    logic clk = 1'b0;
    logic rst;
    logic rpi_clk;
    logic serial;
    logic ready;
    logic rpi_interrupt;
    logic signed [WIDTH-1:0] data;
    logic [0:0] channel;
    logic data_valid;
    logic [6:0] level;
    logic overflow;
    logic underrun;

    // Second instance used only to check MSB-first bit order.
    logic rpi_clk_m;
    logic serial_m;
    logic ready_m;
    logic rpi_interrupt_m;
    logic signed [WIDTH-1:0] data_m;
    logic [0:0] channel_m;
    logic data_valid_m;
    logic [6:0] level_m;
    logic overflow_m;
    logic underrun_m;

    logic [WIDTH-1:0] data_u;
    logic [WIDTH-1:0] data_m_u;
    assign data_u   = data;
    assign data_m_u = data_m;

    i2s_serial_sample_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .MSB_FIRST(0),
        .LOW_WATER(LOW), .HIGH_WATER(HIGH)
    ) dut (
        .clk(clk), .rst(rst), .rpi_clk(rpi_clk), .serial(serial), .ready(ready),
        .rpi_interrupt(rpi_interrupt), .data(data), .channel(channel),
        .data_valid(data_valid), .level(level), .overflow(overflow),
        .underrun(underrun)
    );

    i2s_serial_sample_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .MSB_FIRST(1),
        .LOW_WATER(LOW), .HIGH_WATER(HIGH)
    ) dut_msb (
        .clk(clk), .rst(rst), .rpi_clk(rpi_clk_m), .serial(serial_m), .ready(ready_m),
        .rpi_interrupt(rpi_interrupt_m), .data(data_m), .channel(channel_m),
        .data_valid(data_valid_m), .level(level_m), .overflow(overflow_m),
        .underrun(underrun_m)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_unr;
    bit               m_intr;
    int               m_ch;

    // Scoreboard.
    logic [WIDTH-1:0] exp_data[$];
    int               exp_chan[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented sample against the scoreboard.
    always @(negedge clk) begin
        if (!rst && data_valid) begin
            if (exp_data.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got data 0x%0h with no sample outstanding", data_u);
            end else begin
                logic [WIDTH-1:0] e;
                int c;
                e = exp_data.pop_front();
                c = exp_chan.pop_front();
                check("data", 32'(data_u), 32'(e));
                check("channel", 32'(channel), 32'(c));
            end
        end
    end

    // ---------------- model ----------------
    task automatic m_reset();
        m_q.delete();
        exp_data.delete();
        exp_chan.delete();
        m_ovf  = 1'b0;
        m_unr  = 1'b0;
        m_intr = 1'b1;
        m_ch   = 0;
    endtask

    task automatic m_pop();
        exp_chan.push_back(m_ch);
        m_ch = (m_ch + 1) % CHANNELS;
        if (m_q.size() > 0) begin
            exp_data.push_back(m_q.pop_front());
        end else begin
            exp_data.push_back('0);
            m_unr = 1'b1;
        end
    endtask

    task automatic m_push(input logic [WIDTH-1:0] w);
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic m_intr_update();
        if (m_q.size() <= LOW) m_intr = 1'b1;
        else if (m_q.size() >= HIGH) m_intr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst = 1'b1;
        rpi_clk = 1'b0; serial = 1'b0; ready = 1'b0;
        rpi_clk_m = 1'b0; serial_m = 1'b0; ready_m = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // LSB-first word into `dut`; 3 cycles low and 3 high per bit. With
    // `coinc`, `ready` is strobed on the edge on which the synchronised
    // rising edge of the last bit completes the word: rpi_clk rises before
    // clock edge 0, appears after the 2-flop synchroniser at edge 1, and the
    // push happens at edge 2.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit coinc);
        for (int b = 0; b < WIDTH; b++) begin
            rpi_clk = 1'b0;
            serial  = w[b];
            repeat (3) @(negedge clk);
            rpi_clk = 1'b1;
            repeat (2) @(negedge clk);
            if (b == WIDTH - 1 && coinc) begin
                ready = 1'b1;
                m_pop();
            end
            @(negedge clk);
            ready = 1'b0;
        end
        rpi_clk = 1'b0;
        m_push(w);
        m_intr_update();
    endtask

    task automatic send_word_msb(input logic [WIDTH-1:0] w);
        for (int b = 0; b < WIDTH; b++) begin
            rpi_clk_m = 1'b0;
            serial_m  = w[WIDTH-1-b];
            repeat (3) @(negedge clk);
            rpi_clk_m = 1'b1;
            repeat (3) @(negedge clk);
        end
        rpi_clk_m = 1'b0;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        m_pop();
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        m_intr_update();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, 32'(level), 32'(m_q.size()));
        check({tag, "_irq"}, 32'(rpi_interrupt), 32'(m_intr));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_underrun"}, 32'(underrun), 32'(m_unr));
    endtask

    // Watchdog: no wait may hang the run.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Reset state.
        check("rst_level", 32'(level), 0);
        check("rst_data", 32'(data_u), 0);
        check("rst_irq", 32'(rpi_interrupt), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_channel", 32'(channel), 0);
        check("rst_valid", 32'(data_valid), 0);

        // Bit order, LSB-first instance (the monitor checks data and channel).
        send_word(16'h1234, 1'b0);
        check_state("bitorder");
        pulse_ready();

        // Bit order, MSB-first instance.
        send_word_msb(16'h1234);
        check("msb_level", 32'(level_m), 1);
        ready_m = 1'b1;
        @(negedge clk);
        ready_m = 1'b0;
        check("msb_valid", 32'(data_valid_m), 1);
        check("msb_data", 32'(data_m_u), 32'h1234);
        check("msb_channel", 32'(channel_m), 0);

        // Underrun: two strobes while empty; the channel goes 1, then 0.
        pulse_ready();
        pulse_ready();
        check_state("underrun");

        // Watermark hysteresis.
        do_reset();
        for (int i = 0; i < 48; i++) begin
            send_word(WIDTH'($urandom), 1'b0);
            check("wm_fill_irq", 32'(rpi_interrupt), 32'(m_intr));
        end
        check_state("wm_full48");
        for (int i = 0; i < 31; i++) begin
            pulse_ready();
            check("wm_drain_irq", 32'(rpi_interrupt), 32'(m_intr));
        end
        check_state("wm_level17");
        pulse_ready();
        check_state("wm_level16");
        while (m_q.size() > 0) pulse_ready();

        // Overflow: 65 words with no reads; word 64 is lost.
        do_reset();
        for (int i = 0; i <= 64; i++) send_word(WIDTH'(i), 1'b0);
        check_state("ovf_full");
        for (int i = 0; i < 64; i++) pulse_ready();
        check("ovf_drained_level", 32'(level), 0);

        // Simultaneous push and pop at level 1, across the pointer wrap.
        do_reset();
        send_word(WIDTH'($urandom), 1'b0);
        for (int i = 0; i < 200; i++) begin
            send_word(WIDTH'($urandom), 1'b1);
            check_state("stream");
        end
        pulse_ready();

        // Randomised mix of pushes, coincident push/pops and pops.
        do_reset();
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 3))
                0: send_word(WIDTH'($urandom), 1'b0);
                1: send_word(WIDTH'($urandom), 1'b1);
                default: pulse_ready();
            endcase
            check_state("random");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_data.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
